// File: rtl/vsram_burst_read.sv
// vsram_burst_read
//   Read-side companion to the vSRAM write path. Takes one burst-read request
//   (bank, start column, word count) and issues one read per cycle to the
//   selected bank out of four. Each returned word is presented in order with a
//   valid strobe, and a done pulse marks the end of the burst.
//
//   State | meaning
//   IDLE  | waiting for in_readStart; request inputs sampled only here
//   ISSUE | one read per cycle on the latched bank, column auto-increments
//   DRAIN | enables off, waiting for the last word to come back
//   DONE  | one-cycle done pulse (coincides with the last valid word)
//
// Ports
//   clock, reset                    single clock, synchronous active-high reset
//   in_readStart                    request strobe, ignored while out_busy=1
//   in_vsramNum                     bank select 0..3 (bank 0 = sram_1)
//   in_startCol                     first column, wraps modulo 2**ADDR_W
//   in_burstLen                     word count, 0 = empty burst
//   sram_k_readData                 bank read data, RD_LAT cycles after enable
//   sram_k_readAddressline/Enable   registered bank read port, all-ones when idle
//   out_readData/out_readValid      registered returned word, 0 when not valid
//   out_busy                        accept cycle through done cycle inclusive
//   readVsramDoneFlag               one-cycle completion pulse
//
// RD_LAT must lie in 1..4; the drain counter is sized for that range.

module vsram_burst_read #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 48,
  parameter int LEN_W  = 9,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_readStart,
  input  logic [1:0]        in_vsramNum,
  input  logic [ADDR_W-1:0] in_startCol,
  input  logic [LEN_W-1:0]  in_burstLen,
  input  logic [DATA_W-1:0] sram_1_readData,
  input  logic [DATA_W-1:0] sram_2_readData,
  input  logic [DATA_W-1:0] sram_3_readData,
  input  logic [DATA_W-1:0] sram_4_readData,
  output logic [ADDR_W-1:0] sram_1_readAddressline,
  output logic [ADDR_W-1:0] sram_2_readAddressline,
  output logic [ADDR_W-1:0] sram_3_readAddressline,
  output logic [ADDR_W-1:0] sram_4_readAddressline,
  output logic              sram_1_readEnable,
  output logic              sram_2_readEnable,
  output logic              sram_3_readEnable,
  output logic              sram_4_readEnable,
  output logic [DATA_W-1:0] out_readData,
  output logic              out_readValid,
  output logic              out_busy,
  output logic              readVsramDoneFlag
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_IDLE = '1;
  localparam logic [2:0]        DRAIN_LOAD = 3'(RD_LAT - 1);

  state_t            state;
  logic [1:0]        bank;
  logic [ADDR_W-1:0] col;
  logic [LEN_W-1:0]  remaining;
  logic [2:0]        drain_cnt;
  logic [3:0]        rd_en;
  logic [ADDR_W-1:0] rd_addr [4];

  // Return-path tags: stage j describes the bank read issued j+1 cycles ago,
  // so the last stage lines up with the cycle the bank data is valid.
  logic [RD_LAT-1:0] tag_v;
  logic [1:0]        tag_b [RD_LAT];
  logic [DATA_W-1:0] bank_data;

  // Sequencer. Enables/addresses default to idle every cycle and are only
  // raised for the cycle of an issue, so they stay registered and glitch-free.
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      bank              <= '0;
      col               <= '0;
      remaining         <= '0;
      drain_cnt         <= '0;
      rd_en             <= '0;
      for (int b = 0; b < 4; b++) rd_addr[b] <= ADDR_IDLE;
      out_busy          <= 1'b0;
      readVsramDoneFlag <= 1'b0;
    end else begin
      rd_en             <= '0;
      for (int b = 0; b < 4; b++) rd_addr[b] <= ADDR_IDLE;
      readVsramDoneFlag <= 1'b0;
      case (state)
        IDLE: begin
          if (in_readStart) begin
            bank     <= in_vsramNum;
            out_busy <= 1'b1;
            if (in_burstLen == '0) begin
              state             <= DONE;
              readVsramDoneFlag <= 1'b1;
            end else begin
              // First read goes out on the accept edge so it is visible
              // in the very next cycle.
              state                <= ISSUE;
              rd_en[in_vsramNum]   <= 1'b1;
              rd_addr[in_vsramNum] <= in_startCol;
              col                  <= in_startCol + 1'b1;
              remaining            <= in_burstLen - 1'b1;
            end
          end
        end
        ISSUE: begin
          if (remaining == '0) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end else begin
            rd_en[bank]   <= 1'b1;
            rd_addr[bank] <= col;
            col           <= col + 1'b1;
            remaining     <= remaining - 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state             <= DONE;
            readVsramDoneFlag <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        DONE: begin
          out_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data is steered by the tag that travelled with the read, never by the
  // live bank select, so stray bank data outside a tagged slot is dropped.
  always_comb begin
    bank_data = '0;
    case (tag_b[RD_LAT-1])
      2'd0: bank_data = sram_1_readData;
      2'd1: bank_data = sram_2_readData;
      2'd2: bank_data = sram_3_readData;
      2'd3: bank_data = sram_4_readData;
      default: bank_data = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_v         <= '0;
      for (int j = 0; j < RD_LAT; j++) tag_b[j] <= '0;
      out_readValid <= 1'b0;
      out_readData  <= '0;
    end else begin
      tag_v[0] <= |rd_en;
      tag_b[0] <= bank;
      for (int j = 1; j < RD_LAT; j++) begin
        tag_v[j] <= tag_v[j-1];
        tag_b[j] <= tag_b[j-1];
      end
      out_readValid <= tag_v[RD_LAT-1];
      out_readData  <= tag_v[RD_LAT-1] ? bank_data : '0;
    end
  end

  assign sram_1_readEnable      = rd_en[0];
  assign sram_2_readEnable      = rd_en[1];
  assign sram_3_readEnable      = rd_en[2];
  assign sram_4_readEnable      = rd_en[3];
  assign sram_1_readAddressline = rd_addr[0];
  assign sram_2_readAddressline = rd_addr[1];
  assign sram_3_readAddressline = rd_addr[2];
  assign sram_4_readAddressline = rd_addr[3];

endmodule

// File: tb/tb_vsram_burst_read.sv
// Bench for vsram_burst_read: one instance with RD_LAT=1 and one with RD_LAT=3
// share clock, reset and request inputs. A behavioural SRAM per bank returns a
// word derived from bank and address (random junk when not enabled).
module tb_vsram_burst_read;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  num;
  logic [8:0]  col;
  logic [8:0]  len;
  logic [47:0] rdata  [2][4];
  logic [8:0]  addr_o [2][4];
  logic        en_o   [2][4];
  logic [47:0] data_o [2];
  logic        valid_o[2];
  logic        busy_o [2];
  logic        done_o [2];
  logic [47:0] pipe   [2][4][4];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [47:0] word_of(input int b, input logic [8:0] a);
    return {8'hB0 + 8'(b), 24'(a) * 24'd3 + 24'h05A5A0, 7'd0, a};
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 4; b++) begin
        for (int s = 3; s > 0; s--) pipe[i][b][s] <= pipe[i][b][s-1];
        pipe[i][b][0] <= en_o[i][b] ? word_of(b, addr_o[i][b]) : {16'($urandom), $urandom};
      end
  end

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      rdata[0][b] = pipe[0][b][0];
      rdata[1][b] = pipe[1][b][2];
    end
  end

  vsram_burst_read #(.RD_LAT(1)) u_dut (
    .clock(clock), .reset(reset), .in_readStart(start), .in_vsramNum(num),
    .in_startCol(col), .in_burstLen(len),
    .sram_1_readData(rdata[0][0]), .sram_2_readData(rdata[0][1]),
    .sram_3_readData(rdata[0][2]), .sram_4_readData(rdata[0][3]),
    .sram_1_readAddressline(addr_o[0][0]), .sram_2_readAddressline(addr_o[0][1]),
    .sram_3_readAddressline(addr_o[0][2]), .sram_4_readAddressline(addr_o[0][3]),
    .sram_1_readEnable(en_o[0][0]), .sram_2_readEnable(en_o[0][1]),
    .sram_3_readEnable(en_o[0][2]), .sram_4_readEnable(en_o[0][3]),
    .out_readData(data_o[0]), .out_readValid(valid_o[0]), .out_busy(busy_o[0]),
    .readVsramDoneFlag(done_o[0])
  );

  vsram_burst_read #(.RD_LAT(3)) u_dut3 (
    .clock(clock), .reset(reset), .in_readStart(start), .in_vsramNum(num),
    .in_startCol(col), .in_burstLen(len),
    .sram_1_readData(rdata[1][0]), .sram_2_readData(rdata[1][1]),
    .sram_3_readData(rdata[1][2]), .sram_4_readData(rdata[1][3]),
    .sram_1_readAddressline(addr_o[1][0]), .sram_2_readAddressline(addr_o[1][1]),
    .sram_3_readAddressline(addr_o[1][2]), .sram_4_readAddressline(addr_o[1][3]),
    .sram_1_readEnable(en_o[1][0]), .sram_2_readEnable(en_o[1][1]),
    .sram_3_readEnable(en_o[1][2]), .sram_4_readEnable(en_o[1][3]),
    .out_readData(data_o[1]), .out_readValid(valid_o[1]), .out_busy(busy_o[1]),
    .readVsramDoneFlag(done_o[1])
  );

  // Drives one request, pushes the expected read addresses and words into
  // scoreboard queues, then walks the cycles after the accept edge comparing
  // the instance against them. Cycle k=1 is the first cycle after the accept.
  task automatic run_burst(input string name, input int inst, input int lat,
                           input logic [1:0] b, input logic [8:0] c, input logic [8:0] n,
                           input int tail, input bit inject,
                           output int done_cyc, output int first_en_cyc);
    logic [8:0]  exp_addr[$];
    logic [47:0] exp_data[$];
    logic [8:0]  a;
    logic        exp_en, exp_v, exp_d, exp_b;
    int          e0, last_k, n_en, n_val;
    for (int i = 0; i < int'(n); i++) begin
      a = c + 9'(i);
      exp_addr.push_back(a);
      exp_data.push_back(word_of(b, a));
    end
    start = 1'b1; num = b; col = c; len = n;
    @(posedge clock); #1;
    e0 = cyc;
    start = 1'b0; num = 2'($urandom); col = 9'($urandom); len = 9'($urandom);
    last_k = (n == 0) ? 1 : int'(n) + lat + 1;
    done_cyc = -1; first_en_cyc = -1; n_en = 0; n_val = 0;
    for (int k = 1; k <= last_k + tail; k++) begin
      @(negedge clock);
      if (inject && k == 2) begin
        start = 1'b1; num = 2'd3; col = 9'd300; len = 9'd5;
      end else start = 1'b0;
      for (int bb = 0; bb < 4; bb++) begin
        exp_en = (bb == int'(b)) && (k <= int'(n));
        checks++;
        if (en_o[inst][bb] !== exp_en) begin
          failures++;
          $display("FAIL %s enable bank%0d k=%0d got %b want %b", name, bb, k, en_o[inst][bb], exp_en);
        end
        if (en_o[inst][bb] === 1'b1) begin
          if (first_en_cyc < 0) first_en_cyc = cyc;
          n_en++;
          checks++;
          if (exp_addr.size() == 0) begin
            failures++;
            $display("FAIL %s extra enable bank%0d k=%0d addr %0d want none", name, bb, k, addr_o[inst][bb]);
          end else begin
            a = exp_addr.pop_front();
            if (addr_o[inst][bb] !== a) begin
              failures++;
              $display("FAIL %s addr bank%0d k=%0d got %0d want %0d", name, bb, k, addr_o[inst][bb], a);
            end
          end
        end else begin
          checks++;
          if (addr_o[inst][bb] !== 9'h1FF) begin
            failures++;
            $display("FAIL %s idle addr bank%0d k=%0d got %0d want 511", name, bb, k, addr_o[inst][bb]);
          end
        end
      end
      exp_v = (n != 0) && (k >= lat + 2) && (k <= int'(n) + lat + 1);
      checks++;
      if (valid_o[inst] !== exp_v) begin
        failures++;
        $display("FAIL %s valid k=%0d got %b want %b", name, k, valid_o[inst], exp_v);
      end
      if (valid_o[inst] === 1'b1) begin
        n_val++;
        checks++;
        if (exp_data.size() == 0) begin
          failures++;
          $display("FAIL %s extra word k=%0d got %h want none", name, k, data_o[inst]);
        end else if (data_o[inst] !== exp_data[0]) begin
          failures++;
          $display("FAIL %s data k=%0d got %h want %h", name, k, data_o[inst], exp_data[0]);
          void'(exp_data.pop_front());
        end else void'(exp_data.pop_front());
      end else begin
        checks++;
        if (data_o[inst] !== 48'd0) begin
          failures++;
          $display("FAIL %s idle data k=%0d got %h want 0", name, k, data_o[inst]);
        end
      end
      exp_d = (k == last_k);
      exp_b = (k <= last_k);
      if (done_o[inst] === 1'b1 && done_cyc < 0) done_cyc = cyc;
      checks++;
      if (done_o[inst] !== exp_d) begin
        failures++;
        $display("FAIL %s done k=%0d got %b want %b", name, k, done_o[inst], exp_d);
      end
      checks++;
      if (busy_o[inst] !== exp_b) begin
        failures++;
        $display("FAIL %s busy k=%0d got %b want %b", name, k, busy_o[inst], exp_b);
      end
    end
    start = 1'b0;
    checks++;
    if (n_en != int'(n) || n_val != int'(n)) begin
      failures++;
      $display("FAIL %s counts got en=%0d valid=%0d want %0d", name, n_en, n_val, n);
    end
    checks++;
    if (exp_addr.size() != 0 || exp_data.size() != 0) begin
      failures++;
      $display("FAIL %s leftover got addr=%0d data=%0d want 0", name, exp_addr.size(), exp_data.size());
    end
  endtask

  task automatic check_reset_values(input string name);
    for (int i = 0; i < 2; i++) begin
      for (int bb = 0; bb < 4; bb++) begin
        checks++;
        if (en_o[i][bb] !== 1'b0 || addr_o[i][bb] !== 9'h1FF) begin
          failures++;
          $display("FAIL %s inst%0d bank%0d got en=%b addr=%0d want en=0 addr=511", name, i, bb, en_o[i][bb], addr_o[i][bb]);
        end
      end
      checks++;
      if (valid_o[i] !== 1'b0 || data_o[i] !== 48'd0 || busy_o[i] !== 1'b0 || done_o[i] !== 1'b0) begin
        failures++;
        $display("FAIL %s inst%0d got valid=%b data=%h busy=%b done=%b want all 0", name, i, valid_o[i], data_o[i], busy_o[i], done_o[i]);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; num = '0; col = '0; len = '0;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_single();
    int d, f;
    run_burst("single", 0, 1, 2'd2, 9'd5, 9'd1, 3, 1'b0, d, f);
    checks++;
    if (d - f != 2) begin
      failures++;
      $display("FAIL single enable_to_done got %0d want 2", d - f);
    end
  endtask

  task automatic test_wrap();
    int d, f;
    run_burst("wrap", 0, 1, 2'd0, 9'd510, 9'd4, 3, 1'b0, d, f);
  endtask

  task automatic test_empty();
    int d, f;
    run_burst("empty", 0, 1, 2'd1, 9'd33, 9'd0, 3, 1'b0, d, f);
  endtask

  task automatic test_busy_ignore();
    int d, f;
    run_burst("busy", 0, 1, 2'd1, 9'd40, 9'd3, 6, 1'b1, d, f);
  endtask

  task automatic test_back_to_back();
    int d1, f1, d2, f2;
    run_burst("b2b_first", 0, 1, 2'd3, 9'd200, 9'd2, 1, 1'b0, d1, f1);
    run_burst("b2b_second", 0, 1, 2'd0, 9'd9, 9'd3, 3, 1'b0, d2, f2);
    checks++;
    if (f2 - d1 != 2) begin
      failures++;
      $display("FAIL b2b done_to_first_enable got %0d want 2", f2 - d1);
    end
  endtask

  task automatic test_reset_midburst();
    int seen;
    idle(8);
    start = 1'b1; num = 2'd1; col = 9'd20; len = 9'd8;
    @(posedge clock); #1;
    start = 1'b0;
    seen = 0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clock);
      if (en_o[0][1] === 1'b1) seen++;
    end
    checks++;
    if (seen != 2) begin
      failures++;
      $display("FAIL midreset enables_before got %0d want 2", seen);
    end
    reset = 1'b1;
    @(negedge clock);
    check_reset_values("midreset");
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (valid_o[i] !== 1'b0 || done_o[i] !== 1'b0 || busy_o[i] !== 1'b0 ||
            en_o[i][0] !== 1'b0 || en_o[i][1] !== 1'b0 || en_o[i][2] !== 1'b0 || en_o[i][3] !== 1'b0) begin
          failures++;
          $display("FAIL midreset_after inst%0d k=%0d got valid=%b done=%b busy=%b want all 0", i, k, valid_o[i], done_o[i], busy_o[i]);
        end
      end
    end
  endtask

  task automatic test_lat3();
    int d, f;
    idle(4);
    run_burst("lat3", 1, 3, 2'd3, 9'd100, 9'd2, 3, 1'b0, d, f);
    checks++;
    if (d - f != 5) begin
      failures++;
      $display("FAIL lat3 first_enable_to_done got %0d want 5", d - f);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_empty();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midburst();
    test_lat3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
